// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single port of the 64 x 2-bit bicolor frame memory
// between the LED-matrix scanner (read only), the game logic (read/write) and
// an internal clear engine that fills the whole frame with one colour code.
//
// Ports:
//   clk, nrst                     clock, synchronous active-high reset
//   disp_req/disp_addr            scanner read request and address
//   disp_gnt                      scanner owns the memory port this cycle
//   disp_rvalid/disp_rdata        scanner read return, one cycle after grant
//   game_req/game_we/game_addr/
//   game_wdata                    game access request (write when game_we)
//   game_gnt                      game owns the memory port this cycle
//   game_rvalid/game_rdata        game read return, one cycle after grant
//   clr_req/clr_value             start a full-frame fill with clr_value
//   clr_busy/clr_done             fill in progress / one-cycle end pulse
//   mem_addr/mem_we/mem_wdata     memory port command
//   mem_rdata                     memory read data, one cycle after address
module vram_arbiter #(
  parameter int AW     = 6,
  parameter int DW     = 2,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          game_req,
  input  logic          game_we,
  input  logic [AW-1:0] game_addr,
  input  logic [DW-1:0] game_wdata,
  output logic          game_gnt,
  output logic          game_rvalid,
  output logic [DW-1:0] game_rdata,
  input  logic          clr_req,
  input  logic [DW-1:0] clr_value,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] fill_reg;
  logic [1:0]    wait_cnt;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic [DW-1:0] disp_rdata_q;
  logic [DW-1:0] game_rdata_q;
  logic          game_starved;
  logic          clr_last;

  assign game_starved = (wait_cnt == 2'(STARVE));
  assign clr_last     = &clr_cnt;
  assign clr_busy     = (state == CLEAR);

  // Read data is presented in the rvalid cycle straight from the memory and
  // captured there, so it stays stable until the next read of that port.
  assign disp_rdata = disp_rvalid ? mem_rdata : disp_rdata_q;
  assign game_rdata = game_rvalid ? mem_rdata : game_rdata_q;

  // Arbitration and memory port mux. With no winner the port keeps its last
  // address and data so the memory bus does not toggle needlessly. While
  // reset is asserted nothing is granted and no write is issued, which is what
  // stops an interrupted clear from writing its current cell.
  always_comb begin
    state_next = state;
    disp_gnt   = 1'b0;
    game_gnt   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = last_addr;
    mem_wdata  = last_wdata;
    if (!nrst) begin
      case (state)
        IDLE: begin
          if (clr_req) state_next = CLEAR;
          if (game_req && game_starved) game_gnt = 1'b1;
          else if (disp_req)            disp_gnt = 1'b1;
          else if (game_req)            game_gnt = 1'b1;
          if (disp_gnt) begin
            mem_addr = disp_addr;
          end else if (game_gnt) begin
            mem_addr  = game_addr;
            mem_we    = game_we;
            mem_wdata = game_wdata;
          end
        end
        CLEAR: begin
          mem_we    = 1'b1;
          mem_addr  = clr_cnt;
          mem_wdata = fill_reg;
          if (clr_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, clear counter, starvation counter and read-return pipeline.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      fill_reg     <= '0;
      wait_cnt     <= '0;
      last_addr    <= '0;
      last_wdata   <= '0;
      disp_rvalid  <= 1'b0;
      game_rvalid  <= 1'b0;
      disp_rdata_q <= '0;
      game_rdata_q <= '0;
      clr_done     <= 1'b0;
    end else begin
      state       <= state_next;
      last_addr   <= mem_addr;
      last_wdata  <= mem_wdata;
      disp_rvalid <= disp_gnt;
      game_rvalid <= game_gnt & ~game_we;
      if (disp_rvalid) disp_rdata_q <= mem_rdata;
      if (game_rvalid) game_rdata_q <= mem_rdata;
      clr_done <= (state == CLEAR) && clr_last;

      if (state == IDLE) begin
        if (clr_req) begin
          fill_reg <= clr_value;
          clr_cnt  <= '0;
        end
        // Denials accumulate only while the game keeps asking; the count
        // saturates so the starved game keeps priority until served.
        if (!game_req || game_gnt)  wait_cnt <= '0;
        else if (!game_starved)     wait_cnt <= wait_cnt + 2'd1;
      end else begin
        // Natural wrap takes clr_cnt from the last cell back to 0 on exit.
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter with a behavioural
// 64 x 2-bit synchronous-read frame memory attached to the memory port.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       nrst;
  logic       disp_req;
  logic [5:0] disp_addr;
  logic       disp_gnt, disp_rvalid;
  logic [1:0] disp_rdata;
  logic       game_req, game_we;
  logic [5:0] game_addr;
  logic [1:0] game_wdata;
  logic       game_gnt, game_rvalid;
  logic [1:0] game_rdata;
  logic       clr_req;
  logic [1:0] clr_value;
  logic       clr_busy, clr_done;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  logic       preload;
  logic [1:0] mem [64];
  logic [1:0] exp_mem [64];

  int errors = 0;
  int checks = 0;

  vram_arbiter #(.AW(6), .DW(2), .STARVE(3)) dut (
    .clk(clk), .nrst(nrst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
    .game_wdata(game_wdata), .game_gnt(game_gnt),
    .game_rvalid(game_rvalid), .game_rdata(game_rdata),
    .clr_req(clr_req), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  // Frame memory: write at the edge ending the command cycle, read data
  // available the cycle after the address. Preloaded with i%4.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 2'(i % 4);
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       disp_req;
    logic [5:0] disp_addr;
    logic       game_req;
    logic       game_we;
    logic [5:0] game_addr;
    logic [1:0] game_wdata;
    logic       e_dgnt;
    logic       e_ggnt;
    logic       e_we;
    logic [5:0] e_addr;
    logic [1:0] e_wdata;
    logic       e_drv;
    logic       e_grv;
    logic [1:0] e_rdata;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(int dr, int da, int gr, int gw, int ga, int gd,
                              int edg, int egg, int ewe, int ea, int ewd,
                              int edrv, int egrv, int erd);
    vec_t v;
    v.disp_req = 1'(dr);  v.disp_addr = 6'(da);
    v.game_req = 1'(gr);  v.game_we = 1'(gw);
    v.game_addr = 6'(ga); v.game_wdata = 2'(gd);
    v.e_dgnt = 1'(edg);   v.e_ggnt = 1'(egg);  v.e_we = 1'(ewe);
    v.e_addr = 6'(ea);    v.e_wdata = 2'(ewd);
    v.e_drv = 1'(edrv);   v.e_grv = 1'(egrv);  v.e_rdata = 2'(erd);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    disp_req   = v.disp_req;
    disp_addr  = v.disp_addr;
    game_req   = v.game_req;
    game_we    = v.game_we;
    game_addr  = v.game_addr;
    game_wdata = v.game_wdata;
  endtask

  // Display reads every cell back to back and compares with exp_mem.
  task automatic readAll(input string tag);
    for (int i = 0; i <= 64; i++) begin
      @(posedge clk); #1;
      disp_req  = (i < 64);
      disp_addr = 6'(i % 64);
      @(negedge clk);
      if (i < 64) checkOutput({tag, "_gnt"}, int'(disp_gnt), 1);
      if (i > 0) begin
        checkOutput({tag, "_rvalid"}, int'(disp_rvalid), 1);
        checkOutput($sformatf("%s_cell%0d", tag, i - 1), int'(disp_rdata), int'(exp_mem[i - 1]));
      end
    end
    disp_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad, busy_cnt, gnt_during, done_cnt, bad_done, exp_addr;

    nrst = 1'b1; preload = 1'b1;
    disp_req = 0; disp_addr = 0; game_req = 0; game_we = 0;
    game_addr = 0; game_wdata = 0; clr_req = 0; clr_value = 0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 2'(i % 4);

    vecs[0]  = mk(1,12'd5 ,0,0,0 ,0, 1,0,0,5 ,0, 0,0,0);
    vecs[1]  = mk(0,0 ,0,0,0 ,0, 0,0,0,5 ,0, 1,0,1);
    vecs[2]  = mk(0,0 ,1,1,9 ,3, 0,1,1,9 ,3, 0,0,0);
    vecs[3]  = mk(0,0 ,1,0,9 ,0, 0,1,0,9 ,0, 0,0,0);
    vecs[4]  = mk(1,12,1,0,7 ,0, 1,0,0,12,0, 0,1,3);
    vecs[5]  = mk(1,12,1,0,7 ,0, 1,0,0,12,0, 1,0,0);
    vecs[6]  = mk(1,12,1,0,7 ,0, 1,0,0,12,0, 1,0,0);
    vecs[7]  = mk(1,12,1,0,7 ,0, 0,1,0,7 ,0, 1,0,0);
    vecs[8]  = mk(0,0 ,1,1,40,2, 0,1,1,40,2, 0,1,3);
    vecs[9]  = mk(0,0 ,0,0,0 ,0, 0,0,0,40,0, 0,0,0);
    vecs[10] = mk(0,0 ,0,0,0 ,0, 0,0,0,40,0, 0,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1 nrst = 1'b0; preload = 1'b0;
    @(negedge clk);
    checkOutput("rst_gnts", int'({disp_gnt, game_gnt}), 0);
    checkOutput("rst_rvalid", int'({disp_rvalid, game_rvalid}), 0);
    checkOutput("rst_rdata", int'({disp_rdata, game_rdata}), 0);
    checkOutput("rst_clr", int'({clr_busy, clr_done}), 0);
    checkOutput("rst_mem_addr", int'(mem_addr), 0);
    checkOutput("rst_mem_we", int'(mem_we), 0);
    checkOutput("rst_mem_wdata", int'(mem_wdata), 0);

    // Table-driven arbitration, write/read and starvation vectors
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_disp_gnt", k), int'(disp_gnt), int'(vecs[k].e_dgnt));
      checkOutput($sformatf("v%0d_game_gnt", k), int'(game_gnt), int'(vecs[k].e_ggnt));
      checkOutput($sformatf("v%0d_mem_we", k), int'(mem_we), int'(vecs[k].e_we));
      checkOutput($sformatf("v%0d_mem_addr", k), int'(mem_addr), int'(vecs[k].e_addr));
      if (vecs[k].e_we)
        checkOutput($sformatf("v%0d_mem_wdata", k), int'(mem_wdata), int'(vecs[k].e_wdata));
      checkOutput($sformatf("v%0d_disp_rvalid", k), int'(disp_rvalid), int'(vecs[k].e_drv));
      checkOutput($sformatf("v%0d_game_rvalid", k), int'(game_rvalid), int'(vecs[k].e_grv));
      if (vecs[k].e_drv)
        checkOutput($sformatf("v%0d_disp_rdata", k), int'(disp_rdata), int'(vecs[k].e_rdata));
      if (vecs[k].e_grv)
        checkOutput($sformatf("v%0d_game_rdata", k), int'(game_rdata), int'(vecs[k].e_rdata));
    end
    exp_mem[9]  = 2'd3;
    exp_mem[40] = 2'd2;

    // Clear accepted together with a game read, then reset at write 20
    @(posedge clk); #1;
    clr_req = 1; clr_value = 2; game_req = 1; game_we = 0; game_addr = 9;
    @(negedge clk);
    checkOutput("accept_game_gnt", int'(game_gnt), 1);
    checkOutput("accept_busy", int'(clr_busy), 0);
    @(posedge clk); #1;
    clr_req = 0; clr_value = 0; game_req = 0;
    @(negedge clk);
    checkOutput("clr_game_rvalid", int'(game_rvalid), 1);
    checkOutput("clr_game_rdata", int'(game_rdata), 3);
    checkOutput("clr_first_busy", int'(clr_busy), 1);
    checkOutput("clr_first_write", int'({mem_we, mem_addr, mem_wdata}), int'({1'b1, 6'd0, 2'd2}));
    bad = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (!(clr_busy && mem_we && mem_addr == 6'(k) && mem_wdata == 2'd2)) bad++;
    end
    checkOutput("clr_writes_1_19", bad, 0);
    @(negedge clk);
    checkOutput("clr_write20_addr", int'(mem_addr), 20);
    nrst = 1'b1;
    @(posedge clk); #1 nrst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", int'(clr_busy), 0);
    checkOutput("midrst_gnts", int'({disp_gnt, game_gnt}), 0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (mem_we || clr_busy || clr_done) bad++;
      @(negedge clk);
    end
    checkOutput("midrst_no_writes", bad, 0);
    for (int i = 0; i < 20; i++) exp_mem[i] = 2'd2;
    readAll("rb_midrst");

    // Contention: three display grants then one game grant, repeating
    @(posedge clk); #1;
    disp_req = 1; disp_addr = 1; game_req = 1; game_we = 0; game_addr = 2;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("cont%0d_disp", c), int'(disp_gnt), (c % 4 == 3) ? 0 : 1);
      checkOutput($sformatf("cont%0d_game", c), int'(game_gnt), (c % 4 == 3) ? 1 : 0);
    end
    @(posedge clk); #1;
    disp_req = 0; game_req = 0;

    // Full clear with value 1 under display pressure, second request ignored
    @(posedge clk); #1;
    clr_req = 1; clr_value = 1; disp_req = 1; disp_addr = 4;
    @(negedge clk);
    checkOutput("clr2_accept_disp_gnt", int'(disp_gnt), 1);
    @(posedge clk); #1;
    clr_req = 0; clr_value = 0;
    busy_cnt = 0; gnt_during = 0; done_cnt = 0; bad_done = 0; bad = 0; exp_addr = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (clr_busy) begin
        busy_cnt++;
        if (disp_gnt || game_gnt) gnt_during++;
        if (!(mem_we && mem_addr == 6'(exp_addr) && mem_wdata == 2'd1)) bad++;
        exp_addr++;
      end
      if (clr_done) begin
        done_cnt++;
        if (clr_busy || busy_cnt != 64) bad_done++;
      end
      if (c == 10) begin clr_req = 1; clr_value = 3; end
      if (c == 11) begin clr_req = 0; clr_value = 0; end
    end
    disp_req = 0;
    checkOutput("clr2_busy_cycles", busy_cnt, 64);
    checkOutput("clr2_gnt_while_busy", gnt_during, 0);
    checkOutput("clr2_write_seq", bad, 0);
    checkOutput("clr2_done_pulses", done_cnt, 1);
    checkOutput("clr2_done_timing", bad_done, 0);
    for (int i = 0; i < 64; i++) exp_mem[i] = 2'd1;
    readAll("rb_clr2");

    // Idle: no requests, port quiet and address held at last read (63)
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d_quiet", c), int'({mem_we, disp_rvalid, game_rvalid}), 0);
      checkOutput($sformatf("idle%0d_addr", c), int'(mem_addr), 63);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbiter and sequencer for the 64-entry × 2-bit bicolor frame memory that feeds the 8×8 LED matrix scanner. It shares the single memory port between the display scanner (read-only), the game/maze logic (read/write), and an internal clear engine that fills the whole frame with one colour code. It sits between those requesters and the frame memory, and it guarantees the game port forward progress against a continuously requesting scanner.

## Interface
Parameters:
- AW, 6, memory address width (DEPTH = 2^AW = 64 cells)
- DW, 2, pixel code width (0 off, 1 red, 2 green, 3 both)
- STARVE, 3, consecutive game-port denials after which the game port takes priority over display

Ports:
- clk  in  1  system clock (50 MHz)
- nrst  in  1  reset; synchronous, active-high
- disp_req  in  1  scanner read request
- disp_addr  in  AW  scanner read address
- disp_gnt  out  1  scanner access granted this cycle
- disp_rvalid  out  1  disp_rdata valid (registered)
- disp_rdata  out  DW  scanner read data (registered)
- game_req  in  1  game access request
- game_we  in  1  1 = write, 0 = read
- game_addr  in  AW  game address
- game_wdata  in  DW  game write data
- game_gnt  out  1  game access granted this cycle
- game_rvalid  out  1  game_rdata valid (registered)
- game_rdata  out  DW  game read data (registered)
- clr_req  in  1  start a full-frame clear
- clr_value  in  DW  fill code, sampled when clr_req is accepted
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid the cycle after the address is presented

## Operation
- FSM states: IDLE (arbitrate requesters) and CLEAR (internal fill).
- IDLE → CLEAR on clr_req. Captures clr_value into fill_reg and sets clr_cnt = 0. In the acceptance cycle, requesters are still arbitrated normally.
- In CLEAR, each cycle drives mem_we = 1, mem_addr = clr_cnt, mem_wdata = fill_reg, then increments clr_cnt.
- CLEAR → IDLE after the write to address 63. clr_done pulses in the first IDLE cycle.
- clr_req is ignored while in CLEAR. The clear is not restarted, and the new clr_value is not sampled.
- In CLEAR, disp_gnt = game_gnt = 0. Requests are not queued; requesters hold req until granted.
- IDLE priority:
  - game, if game_req and wait_cnt == STARVE;
  - otherwise display, if disp_req;
  - otherwise game, if game_req;
  - otherwise no access (mem_we = 0, mem_addr holds its last value).
- Exactly one grant is asserted at most per cycle. Grants are combinational from the requests and the current state.
- Winner drives the memory port:
  - display: mem_addr = disp_addr, mem_we = 0;
  - game: mem_addr = game_addr, mem_we = game_we, mem_wdata = game_wdata.
- wait_cnt (2-bit, saturating at STARVE):
  - increments when game_req = 1 and game_gnt = 0 in IDLE;
  - clears when game_gnt = 1 or game_req = 0;
  - holds during CLEAR.
- Read return:
  - disp_rvalid / game_rvalid is the granted read delayed by one cycle;
  - the matching rdata register loads mem_rdata in that cycle and holds it otherwise;
  - a game write produces no game_rvalid.

## Timing
- Reset (nrst = 1 at a clk edge), applied in any state including mid-clear:
  - state = IDLE, clr_cnt = 0, wait_cnt = 0, fill_reg = 0;
  - disp_rvalid = game_rvalid = 0, disp_rdata = game_rdata = 0, clr_busy = 0, clr_done = 0;
  - mem_addr = 0, mem_we = 0, mem_wdata = 0, grants = 0.
  - A clear that is cut short by reset is abandoned; it does not resume.
- Read latency:
  - grant in cycle N, data returned in cycle N+1;
  - back-to-back grants give one read per cycle.
- Write: takes effect at the clk edge ending the grant cycle.
- Clear:
  - accepted in cycle N;
  - clr_busy = 1 in cycles N+1 … N+64, with writes to addresses 0…63;
  - clr_done = 1 in cycle N+65, clr_busy = 0.
- Simultaneous game read and pending clear: a game read granted in the clr_req cycle still returns its rvalid one cycle later, during CLEAR.
- Address wrap: clr_cnt wraps from 63 to 0 on exit and is never observed as 64.

## Test plan
- Reset mid-clear: start a clear with clr_value = 2, assert nrst at write 20. Required: next cycle clr_busy = 0, all grants 0, no further writes. A subsequent full read shows addresses 0–19 = 2 and 20–63 unchanged.
- Single requester:
  - game writes 3 to address 9, then reads address 9 → game_rvalid one cycle after the read grant, game_rdata = 3;
  - display reads address 9 → disp_rdata = 3.
- Contention: disp_req and game_req held high together. Required: disp_gnt for 3 cycles, then game_gnt for 1 cycle, repeating; wait_cnt returns to 0 after each game grant.
- Clear: clr_req with clr_value = 1 while disp_req is high. Required: clr_busy = 1 for exactly 64 cycles with no disp_gnt; clr_done pulses once; all 64 cells read back as 1.
- Clear ignored: a second clr_req with clr_value = 3 during a clear. Required: total busy time stays 64 cycles, and all cells read back as the first value.
- Idle: no requests for 10 cycles → mem_we = 0, no rvalid pulses, mem_addr unchanged.
